bp_fe_instr_aligner: RTL and testbench

- Sits between the I$ fetch-data return and the FE instruction scan/predecode stage.
- Turns a stream of 4-byte-aligned 32-bit fetch words into a stream of whole instructions, one per handshake. Each instruction is either compressed (16b, zero-extended to 32b) or full 32b, and carries its own PC.
- Handles 32-bit instructions that straddle two fetch words by holding the leading halfword across words.
- Redirects flush the held state and re-establish halfword alignment.

---
 rtl/bp_fe_instr_aligner.sv | 135 +++++++++++++
 tb/tb_bp_fe_instr_aligner.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_instr_aligner.sv
// Front-end instruction aligner.
// Splits 32b fetch words into whole 16b/32b instructions with PCs.
module bp_fe_instr_aligner #(
  parameter int vaddr_width_p = 39
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     redirect_v_i,
  input  logic [vaddr_width_p-1:0] redirect_pc_i,
  input  logic                     fetch_v_i,
  input  logic [vaddr_width_p-1:0] fetch_pc_i,
  input  logic [31:0]              fetch_data_i,
  output logic                     fetch_yumi_o,
  output logic                     instr_v_o,
  output logic [vaddr_width_p-1:0] instr_pc_o,
  output logic [31:0]              instr_o,
  output logic                     instr_compressed_o,
  input  logic                     instr_ready_and_i
);

  localparam int instr_width_gp = 32;
  localparam int half_width_lp = instr_width_gp / 2;

  typedef logic [vaddr_width_p-1:0] vaddr_t;
  typedef logic [half_width_lp-1:0] half_t;

  localparam vaddr_t two_lp = vaddr_t'(2);

  typedef enum logic [1:0] {
    e_lo    = 2'd0,
    e_hi    = 2'd1,
    e_split = 2'd2
  } state_e;

  state_e state_r;
  half_t  held_half_r;
  vaddr_t held_pc_r;

  half_t  lo_half;
  half_t  hi_half;
  logic   lo_cmp;
  logic   hi_cmp;
  vaddr_t fetch_pc_p2;
  vaddr_t held_pc_p2;
  logic   active;
  logic   handshake;
  logic   capture;

  assign lo_half = fetch_data_i[half_width_lp-1:0];
  assign hi_half = fetch_data_i[instr_width_gp-1:half_width_lp];
  assign lo_cmp = (lo_half[1:0] != 2'b11);
  assign hi_cmp = (hi_half[1:0] != 2'b11);
  assign fetch_pc_p2 = fetch_pc_i + two_lp;
  assign held_pc_p2 = held_pc_r + two_lp;

  // Reset and redirect both suppress any transfer in this cycle
  assign active = fetch_v_i & ~redirect_v_i & ~reset_i;

  // Output mux: pick the instruction starting at the current halfword
  always_comb begin
    instr_v_o = 1'b0;
    instr_pc_o = fetch_pc_i;
    instr_o = fetch_data_i;
    instr_compressed_o = 1'b0;
    capture = 1'b0;
    unique case (state_r)
      e_lo: begin
        instr_v_o = active;
        instr_pc_o = fetch_pc_i;
        instr_compressed_o = lo_cmp;
        instr_o = lo_cmp ? {16'b0, lo_half} : fetch_data_i;
      end
      e_hi: begin
        instr_v_o = active & hi_cmp;
        instr_pc_o = fetch_pc_p2;
        instr_compressed_o = 1'b1;
        instr_o = {16'b0, hi_half};
        capture = active & ~hi_cmp;
      end
      e_split: begin
        instr_v_o = active;
        instr_pc_o = held_pc_r;
        instr_compressed_o = 1'b0;
        instr_o = {lo_half, held_half_r};
      end
      default: begin
        instr_v_o = 1'b0;
      end
    endcase
  end

  assign handshake = instr_v_o & instr_ready_and_i;

  // Word is consumed once its last halfword has been used or captured
  always_comb begin
    fetch_yumi_o = 1'b0;
    unique case (state_r)
      e_lo:    fetch_yumi_o = handshake & ~lo_cmp;
      e_hi:    fetch_yumi_o = handshake | capture;
      e_split: fetch_yumi_o = 1'b0;
      default: fetch_yumi_o = 1'b0;
    endcase
  end

  // Alignment state and held leading halfword of a straddling instruction
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_lo;
      held_half_r <= '0;
      held_pc_r <= '0;
    end else if (redirect_v_i) begin
      state_r <= redirect_pc_i[1] ? e_hi : e_lo;
      held_half_r <= '0;
      held_pc_r <= '0;
    end else if (capture) begin
      state_r <= e_split;
      held_half_r <= hi_half;
      held_pc_r <= fetch_pc_p2;
    end else if (handshake) begin
      unique case (state_r)
        e_lo:    state_r <= lo_cmp ? e_hi : e_lo;
        e_hi:    state_r <= e_lo;
        e_split: state_r <= e_hi;
        default: state_r <= e_lo;
      endcase
    end
  end

  // The word completing a split instruction must follow the held half
  always_ff @(posedge clk_i) begin
    if (active && state_r == e_split)
      assert (fetch_pc_i == held_pc_p2);
  end

endmodule

// File: tb/tb_bp_fe_instr_aligner.sv
// Directed scoreboard bench for bp_fe_instr_aligner.
// Expected outputs are queued per step and compared each cycle.
module tb_bp_fe_instr_aligner;

  localparam int VW = 39;

  typedef struct packed {
    logic          v;
    logic [VW-1:0] pc;
    logic [31:0]   instr;
    logic          cmp;
    logic          yumi;
  } exp_t;

  logic          clk;
  logic          reset_i;
  logic          redirect_v_i;
  logic [VW-1:0] redirect_pc_i;
  logic          fetch_v_i;
  logic [VW-1:0] fetch_pc_i;
  logic [31:0]   fetch_data_i;
  logic          fetch_yumi_o;
  logic          instr_v_o;
  logic [VW-1:0] instr_pc_o;
  logic [31:0]   instr_o;
  logic          instr_compressed_o;
  logic          instr_ready_and_i;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  bp_fe_instr_aligner #(.vaddr_width_p(VW)) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .redirect_v_i(redirect_v_i),
    .redirect_pc_i(redirect_pc_i),
    .fetch_v_i(fetch_v_i),
    .fetch_pc_i(fetch_pc_i),
    .fetch_data_i(fetch_data_i),
    .fetch_yumi_o(fetch_yumi_o),
    .instr_v_o(instr_v_o),
    .instr_pc_o(instr_pc_o),
    .instr_o(instr_o),
    .instr_compressed_o(instr_compressed_o),
    .instr_ready_and_i(instr_ready_and_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic fv, input logic [VW-1:0] pc,
                     input logic [31:0] d, input logic rdy);
    fetch_v_i = fv;
    fetch_pc_i = pc;
    fetch_data_i = d;
    instr_ready_and_i = rdy;
  endtask

  task automatic expect_o(input logic v, input logic [VW-1:0] pc,
                          input logic [31:0] ins, input logic cmp,
                          input logic y);
    exp_t e;
    e.v = v;
    e.pc = pc;
    e.instr = ins;
    e.cmp = cmp;
    e.yumi = y;
    sb.push_back(e);
  endtask

  // Settle, compare against the oldest queued expectation, advance a cycle
  task automatic cyc(input string tag);
    exp_t e;
    #3;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_v"}, 64'(instr_v_o), 64'(e.v));
      chk({tag, "_yumi"}, 64'(fetch_yumi_o), 64'(e.yumi));
      if (e.v) begin
        chk({tag, "_pc"}, 64'(instr_pc_o), 64'(e.pc));
        chk({tag, "_instr"}, 64'(instr_o), 64'(e.instr));
        chk({tag, "_cmp"}, 64'(instr_compressed_o), 64'(e.cmp));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i = 1'b1;
    redirect_v_i = 1'b0;
    redirect_pc_i = '0;
    drv(1'b1, 39'h1000, 32'h0000_0093, 1'b1);
    #1;

    expect_o(0, 0, 0, 0, 0); cyc("rst0");
    expect_o(0, 0, 0, 0, 0); cyc("rst1");
    reset_i = 1'b0;
    drv(1'b0, 39'h0, 32'h0, 1'b1);
    expect_o(0, 0, 0, 0, 0); cyc("post_rst");

    // two compressed in one word
    drv(1'b1, 39'h1000, 32'h0001_0001, 1'b1);
    expect_o(1, 39'h1000, 32'h1, 1, 0); cyc("t1_lo");
    expect_o(1, 39'h1002, 32'h1, 1, 1); cyc("t1_hi");
    drv(1'b1, 39'h1004, 32'h0000_0093, 1'b1);
    expect_o(1, 39'h1004, 32'h93, 0, 1); cyc("t1_back_lo");

    // straddling 32b, capture with ready low still yumis
    drv(1'b1, 39'h2000, 32'h0093_0001, 1'b1);
    expect_o(1, 39'h2000, 32'h1, 1, 0); cyc("t2_lo");
    drv(1'b1, 39'h2000, 32'h0093_0001, 1'b0);
    expect_o(0, 0, 0, 0, 1); cyc("t2_cap");
    drv(1'b1, 39'h2004, 32'h0001_0000, 1'b1);
    expect_o(1, 39'h2002, 32'h93, 0, 0); cyc("t2_split");
    expect_o(1, 39'h2006, 32'h1, 1, 1); cyc("t2_hi");

    // aligned 32b stream, with one back-pressured cycle
    drv(1'b1, 39'h3000, 32'h0000_0093, 1'b0);
    expect_o(1, 39'h3000, 32'h93, 0, 0); cyc("t3_stall");
    drv(1'b1, 39'h3000, 32'h0000_0093, 1'b1);
    expect_o(1, 39'h3000, 32'h93, 0, 1); cyc("t3_w0");
    drv(1'b1, 39'h3004, 32'h0010_0113, 1'b1);
    expect_o(1, 39'h3004, 32'h0010_0113, 0, 1); cyc("t3_w1");
    drv(1'b0, 39'h3008, 32'h0010_0113, 1'b1);
    expect_o(0, 0, 0, 0, 0); cyc("t3_idle");

    // misaligned redirect
    redirect_v_i = 1'b1;
    redirect_pc_i = 39'h4002;
    drv(1'b1, 39'h3008, 32'h0000_0093, 1'b1);
    expect_o(0, 0, 0, 0, 0); cyc("t4_redir");
    redirect_v_i = 1'b0;
    drv(1'b1, 39'h4000, 32'h0001_0000, 1'b1);
    expect_o(1, 39'h4002, 32'h1, 1, 1); cyc("t4_hi");

    // back-pressure and redirect in split
    drv(1'b1, 39'h5000, 32'h0093_0001, 1'b1);
    expect_o(1, 39'h5000, 32'h1, 1, 0); cyc("t5_lo");
    expect_o(0, 0, 0, 0, 1); cyc("t5_cap");
    drv(1'b1, 39'h5004, 32'h0001_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expect_o(1, 39'h5002, 32'h93, 0, 0);
      cyc("t5_bp");
    end
    drv(1'b0, 39'h5004, 32'h0001_0000, 1'b1);
    expect_o(0, 0, 0, 0, 0); cyc("t5_nofv");
    redirect_v_i = 1'b1;
    redirect_pc_i = 39'h5000;
    drv(1'b1, 39'h5004, 32'h0001_0000, 1'b1);
    expect_o(0, 0, 0, 0, 0); cyc("t5_redir");
    redirect_v_i = 1'b0;
    drv(1'b1, 39'h5000, 32'h0000_0093, 1'b1);
    expect_o(1, 39'h5000, 32'h93, 0, 1); cyc("t5_after");

    // reset mid-split
    drv(1'b1, 39'h6000, 32'h0093_0001, 1'b1);
    expect_o(1, 39'h6000, 32'h1, 1, 0); cyc("t6_lo");
    expect_o(0, 0, 0, 0, 1); cyc("t6_cap");
    reset_i = 1'b1;
    drv(1'b1, 39'h6004, 32'h0001_0000, 1'b1);
    expect_o(0, 0, 0, 0, 0); cyc("t6_rst");
    reset_i = 1'b0;
    drv(1'b1, 39'h6000, 32'h0000_0093, 1'b1);
    expect_o(1, 39'h6000, 32'h93, 0, 1); cyc("t6_after");

    // split across the top of the address space
    redirect_v_i = 1'b1;
    redirect_pc_i = 39'h7F_FFFF_FFFE;
    expect_o(0, 0, 0, 0, 0); cyc("t7_redir");
    redirect_v_i = 1'b0;
    drv(1'b1, 39'h7F_FFFF_FFFC, 32'h0093_0000, 1'b1);
    expect_o(0, 0, 0, 0, 1); cyc("t7_cap");
    drv(1'b1, 39'h0, 32'h0000_0001, 1'b1);
    expect_o(1, 39'h7F_FFFF_FFFE, 32'h0001_0093, 0, 0); cyc("t7_split");
    expect_o(1, 39'h2, 32'h0, 1, 1); cyc("t7_hi");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
